// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, states, instruction
// classes and the write-back / next-PC select codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CL_NONE = 3'd0,
    CL_R    = 3'd1,
    CL_I    = 3'd2,
    CL_LW   = 3'd3,
    CL_SW   = 3'd4,
    CL_JAL  = 3'd5,
    CL_BR   = 3'd6
  } class_e;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

  function automatic class_e decode_class(input logic [6:0] op);
    case (op)
      OP_R:    return CL_R;
      OP_I:    return CL_I;
      OP_LW:   return CL_LW;
      OP_SW:   return CL_SW;
      OP_JAL:  return CL_JAL;
      OP_BR:   return CL_BR;
      default: return CL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts cycles spent waiting on mem_ready and flags the
// last permitted waiting cycle so the FSM can trap if ready does not arrive.
module mc_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (tick)
      count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  // High during the TIMEOUT-th waiting cycle; a ready in that same cycle still wins.
  assign expired = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: sequences fetch/decode/execute/memory/
// write-back, traps on illegal opcodes or memory timeouts, counts retirements.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        flag,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_load,
  output logic        mdr_load,
  output logic        alu_src_imm,
  output logic        reg_write_en,
  output logic [1:0]  wb_sel,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        trap,
  output logic [2:0]  state_o,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  class_e      class_q, class_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] instret_q;
  logic        run_q;
  logic        waiting, expired;

  // run_q holds the FSM idle (and mem_req low) until the first edge after reset release.
  assign waiting = run_q && ((state_q == ST_FETCH) || (state_q == ST_MEM));

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!waiting || mem_ready),
    .tick    (waiting && !mem_ready),
    .expired (expired)
  );

  always_comb begin
    state_d      = state_q;
    class_d      = class_q;
    func3_d      = func3_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    mdr_load     = 1'b0;
    alu_src_imm  = 1'b0;
    reg_write_en = 1'b0;
    wb_sel       = WB_ALU;
    pc_write     = 1'b0;
    pc_sel       = PC_PLUS4;
    trap         = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (run_q) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            state_d = ST_DECODE;
          end else if (expired) begin
            state_d = ST_TRAP;
          end
        end
      end
      ST_DECODE: begin
        class_d = decode_class(opcode);
        func3_d = func3;
        state_d = (class_d == CL_NONE) ? ST_TRAP : ST_EXEC;
      end
      ST_EXEC: begin
        case (class_q)
          CL_R:   state_d = ST_WB;
          CL_I: begin
            alu_src_imm = 1'b1;
            state_d     = ST_WB;
          end
          CL_LW, CL_SW: begin
            alu_src_imm = 1'b1;
            state_d     = ST_MEM;
          end
          CL_JAL: state_d = ST_WB;
          CL_BR: begin
            if ((func3_q == F3_BEQ) || (func3_q == F3_BNE)) begin
              pc_write = 1'b1;
              if (((func3_q == F3_BEQ) && flag) || ((func3_q == F3_BNE) && !flag))
                pc_sel = PC_BRANCH;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_TRAP;
            end
          end
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (class_q == CL_SW);
        alu_src_imm  = 1'b1;
        if (mem_ready) begin
          if (class_q == CL_SW) begin
            pc_write = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            mdr_load = 1'b1;
            state_d  = ST_WB;
          end
        end else if (expired) begin
          state_d = ST_TRAP;
        end
      end
      ST_WB: begin
        reg_write_en = 1'b1;
        pc_write     = 1'b1;
        if (class_q == CL_LW) begin
          wb_sel = WB_MDR;
        end else if (class_q == CL_JAL) begin
          wb_sel = WB_PC4;
          pc_sel = PC_JUMP;
        end
        state_d = ST_FETCH;
      end
      ST_TRAP: trap = 1'b1;
      default: state_d = ST_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      class_q   <= CL_NONE;
      func3_q   <= 3'b000;
      instret_q <= 32'd0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      func3_q   <= func3_d;
      run_q     <= 1'b1;
      if (pc_write)
        instret_q <= instret_q + 32'd1;
    end
  end

  assign state_o = state_q;
  assign instret = instret_q;

endmodule
